// File: rtl/lod_seq_pkg.sv
// rtl/lod_seq_pkg.sv - shared types and helpers for the sequential leading-one scanner
package lod_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } lod_seq_state_t;

    function automatic int lod_seq_nib(input int width);
        return width / 4;
    endfunction

    function automatic logic [1:0] lod_seq_enc4(input logic [3:0] d);
        logic [1:0] e;
        e = 2'd0;
        case (d)
            4'b1000: e = 2'd3;
            4'b0100: e = 2'd2;
            4'b0010: e = 2'd1;
            default: e = 2'd0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/lod4_bit.sv
// rtl/lod4_bit.sv - 4-bit leading-one detector, one-hot output plus any-one flag
module lod4_bit (
    input  logic [3:0] a,
    output logic [3:0] d,
    output logic       or_out
);

    assign or_out = |a;
    assign d[3]   = a[3];
    assign d[2]   = ~a[3] & a[2];
    assign d[1]   = ~a[3] & ~a[2] & a[1];
    assign d[0]   = ~(|a[3:1]) & a[0];

endmodule

// File: rtl/lod_seq_scan.sv
// rtl/lod_seq_scan.sv - nibble-serial leading-one detector; LOD_SEQ_BACK2BACK_EN overlaps retire with accept
module lod_seq_scan
    import lod_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_pos,
    output logic             out_zero,
    output logic [WIDTH-2:0] out_frac
);

    localparam int NIB   = lod_seq_nib(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIB - 1);

    lod_seq_state_t   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             zero_q, zero_d;
    logic [WIDTH-2:0] frac_q, frac_d;

    logic [3:0]       nib;
    logic [3:0]       lod_d;
    logic             lod_or;
    logic [POS_W-1:0] hit_pos;
    logic [WIDTH-2:0] hit_frac;
    logic             accept;

    assign nib = data_q[{idx_q, 2'b00} +: 4];

    lod4_bit u_lod (
        .a      (nib),
        .d      (lod_d),
        .or_out (lod_or)
    );

    assign hit_pos  = POS_W'({idx_q, lod_seq_enc4(lod_d)});
    // Shift the leading one out of the top so the bits below it land left-aligned.
    assign hit_frac = (WIDTH-1)'(data_q << (POS_W'(WIDTH - 1) - hit_pos));

`ifdef LOD_SEQ_BACK2BACK_EN
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        pos_d   = pos_q;
        zero_d  = zero_q;
        frac_d  = frac_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    idx_d   = IDX_TOP;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (lod_or) begin
                    pos_d   = hit_pos;
                    frac_d  = hit_frac;
                    zero_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    pos_d   = '0;
                    frac_d  = '0;
                    zero_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    // accept can only be high here when back-to-back operation is built in
                    if (accept) begin
                        data_d  = in_data;
                        idx_d   = IDX_TOP;
                        state_d = SCAN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pos_q   <= '0;
            zero_q  <= 1'b0;
            frac_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pos_q   <= pos_d;
            zero_q  <= zero_d;
            frac_q  <= frac_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pos   = pos_q;
    assign out_zero  = zero_q;
    assign out_frac  = frac_q;

endmodule

// File: tb/tb_lod_seq_scan.sv
// tb/tb_lod_seq_scan.sv - self-checking bench for lod_seq_scan at WIDTH=16
module tb_lod_seq_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_pos;
    logic        out_zero;
    logic [14:0] out_frac;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lod_seq_scan #(.WIDTH(16), .POS_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pos   (out_pos),
        .out_zero  (out_zero),
        .out_frac  (out_frac)
    );

    typedef struct {
        logic [15:0] data;
        int          hold;
        logic [3:0]  pos;
        logic        zero;
        logic [14:0] frac;
        int          lat;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Highest set bit by search; fraction is the remainder below it, scaled to the top.
    function automatic void ref_lod(input logic [15:0] x, output logic [3:0] pos,
                                    output logic zero, output logic [14:0] frac, output int lat);
        int r;
        pos = 4'd0; zero = 1'b1; frac = 15'd0; lat = 4;
        for (int b = 15; b >= 0; b--) begin
            if (zero && x[b]) begin
                pos  = 4'(b);
                zero = 1'b0;
            end
        end
        if (!zero) begin
            r    = (int'(x) - (1 << pos)) << (15 - int'(pos));
            frac = r[14:0];
            lat  = 4 - int'(pos) / 4;
        end
    endfunction

    // Entered and left just after a falling edge.
    task automatic do_op(input string tag, input logic [15:0] d, input int hold,
                         input logic [3:0] e_pos, input logic e_zero,
                         input logic [14:0] e_frac, input int e_lat);
        int t;
        int acc;
        int lat;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_data   = d;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        acc = cyc + 1;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        lat = out_valid ? (cyc - acc) : -1;
        check({tag, "_lat"},  lat, e_lat);
        check({tag, "_pos"},  32'(out_pos), 32'(e_pos));
        check({tag, "_zero"}, 32'(out_zero), 32'(e_zero));
        check({tag, "_frac"}, 32'(out_frac), 32'(e_frac));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"},    32'(out_valid), 1);
            check({tag, "_hold_pos"},      32'(out_pos), 32'(e_pos));
            check({tag, "_hold_frac"},     32'(out_frac), 32'(e_frac));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_retire"}, 32'(out_valid), 0);
    endtask

    vec_t        vecs[6];
    logic [15:0] sdat[4];
    int          acc_e[4];
    logic [3:0]  got_pos[$];
    logic [3:0]  exp_spos[4];
    int          exp_gap[3];
    int          si;
    bit          adv;
    bit          seen;
    int          t;
    logic [15:0] x;
    logic [3:0]  m_pos;
    logic        m_zero;
    logic [14:0] m_frac;
    int          m_lat;

    initial begin
        vecs[0] = '{16'h8001, 0, 4'd15, 1'b0, 15'h0001, 1};
        vecs[1] = '{16'h0013, 0, 4'd4,  1'b0, 15'h1800, 3};
        vecs[2] = '{16'h0000, 0, 4'd0,  1'b1, 15'h0000, 4};
        vecs[3] = '{16'h0400, 5, 4'd10, 1'b0, 15'h0000, 2};
        vecs[4] = '{16'h0F00, 0, 4'd11, 1'b0, 15'h7000, 2};
        vecs[5] = '{16'h0001, 1, 4'd0,  1'b0, 15'h0000, 4};

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_pos",   32'(out_pos), 0);
        check("rst_out_zero",  32'(out_zero), 0);
        check("rst_out_frac",  32'(out_frac), 0);
        check("rst_in_ready",  32'(in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            do_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].hold,
                  vecs[i].pos, vecs[i].zero, vecs[i].frac, vecs[i].lat);

        // Reset pulse during the second scan cycle of 0x00F0.
        in_valid = 1'b1;
        in_data  = 16'h00F0;
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        check("midscan_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("postrst_in_ready", 32'(in_ready), 1);
        check("postrst_valid",    32'(out_valid), 0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("postrst_no_valid", 32'(seen), 0);
        do_op("after_rst", 16'h0002, 0, 4'd1, 1'b0, 15'h0000, 4);

        // Streaming with in_valid held high.
        sdat[0] = 16'h8000; sdat[1] = 16'h0100; sdat[2] = 16'h0001; sdat[3] = 16'h8000;
        exp_spos[0] = 4'd15; exp_spos[1] = 4'd8; exp_spos[2] = 4'd0; exp_spos[3] = 4'd15;
`ifdef LOD_SEQ_BACK2BACK_EN
        exp_gap[0] = 2; exp_gap[1] = 3; exp_gap[2] = 5;
`else
        exp_gap[0] = 3; exp_gap[1] = 4; exp_gap[2] = 6;
`endif
        out_ready = 1'b1;
        si  = 0;
        adv = 1'b0;
        in_valid = 1'b1;
        in_data  = sdat[0];
        for (int c = 0; c < 60; c++) begin
            if (adv) begin
                si++;
                adv = 1'b0;
                if (si < 4) in_data = sdat[si];
                else in_valid = 1'b0;
            end
            if (out_valid && out_ready) got_pos.push_back(out_pos);
            if (in_valid && in_ready) begin
                acc_e[si] = cyc + 1;
                adv = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("stream_accepts", si, 4);
        check("stream_results", got_pos.size(), 4);
        if (si == 4) begin
            for (int i = 0; i < 3; i++)
                check($sformatf("stream_gap%0d", i), acc_e[i+1] - acc_e[i], exp_gap[i]);
        end
        if (got_pos.size() == 4) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("stream_pos%0d", i), 32'(got_pos[i]), 32'(exp_spos[i]));
        end

        for (int n = 0; n < 40; n++) begin
            x = 16'($urandom);
            x = x >> $urandom_range(0, 16);
            ref_lod(x, m_pos, m_zero, m_frac, m_lat);
            do_op($sformatf("rnd%0d_%04h", n, x), x, int'($urandom_range(0, 2)),
                  m_pos, m_zero, m_frac, m_lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
